// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver with a one-deep valid/ready output register.
//
// Each bit_en strobe samples one bit from SI. frame=1 together with bit_en marks the
// first bit of a word. It also resyncs the receiver, so a partial word is dropped.
// A completed WIDTH-bit word goes into the output register (Dout / Dout_valid).
// If the register still holds an unconsumed word, the new word is dropped and the
// sticky overrun flag is set.
//
// Optional feature, macro SIPO_RX_PARITY_EN: an even-parity bit follows the data
// bits, and the word is delivered on the parity strobe with par_err.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   SI          serial data in
//   bit_en      bit strobe
//   frame       start-of-word marker, qualified by bit_en
//   Dout        received word, stable while Dout_valid=1
//   Dout_valid  Dout holds an unconsumed word
//   Dout_ready  downstream accepts Dout when Dout_valid=1
//   busy        a word is partially received
//   bit_cnt     data bits received for the current word
//   overrun     sticky, a completed word was dropped
//   clr_ovr     clears overrun
//   par_err     (SIPO_RX_PARITY_EN only) parity error for Dout
module sipo_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SI,
  input  logic                       bit_en,
  input  logic                       frame,
  output logic [WIDTH-1:0]           Dout,
  output logic                       Dout_valid,
  input  logic                       Dout_ready,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  input  logic                       clr_ovr
`ifdef SIPO_RX_PARITY_EN
  ,
  output logic                       par_err
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  sh_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  dout_q;
  logic              dout_valid_q;
  logic              overrun_q;
`ifdef SIPO_RX_PARITY_EN
  logic              par_err_q;
`endif

  logic [WIDTH-1:0]  sh_shift;
  logic [WIDTH-1:0]  sh_first;
  logic [WIDTH-1:0]  word;
  logic              last_bit;
  logic              deliver;
  logic              accept;
  logic              drop;

  always_comb begin
    sh_shift = MSB_FIRST ? {sh_q[WIDTH-2:0], SI} : {SI, sh_q[WIDTH-1:1]};
    sh_first = MSB_FIRST ? {{(WIDTH-1){1'b0}}, SI} : {SI, {(WIDTH-1){1'b0}}};
    // The strobe that samples data bit number WIDTH.
    last_bit = bit_en && !frame && (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));
`ifdef SIPO_RX_PARITY_EN
    deliver  = bit_en && !frame && (state_q == StPar);
    word     = sh_q;
`else
    deliver  = last_bit;
    word     = sh_shift;
`endif
    // A pop on the same edge frees the register, so the push needs no bubble.
    accept   = deliver && (!dout_valid_q || Dout_ready);
    drop     = deliver && dout_valid_q && !Dout_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      // Receive side.
      if (bit_en) begin
        if (frame) begin
          sh_q    <= sh_first;
          cnt_q   <= CntW'(1);
          state_q <= StShift;
        end else begin
          unique case (state_q)
            StShift: begin
              sh_q <= sh_shift;
              if (last_bit) begin
`ifdef SIPO_RX_PARITY_EN
                cnt_q   <= CntW'(WIDTH);
                state_q <= StPar;
`else
                cnt_q   <= '0;
                state_q <= StIdle;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            StPar: begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end
            default: ;  // StIdle: a bit outside a word is ignored
          endcase
        end
      end

      // Output register.
      if (accept) begin
        dout_q       <= word;
        dout_valid_q <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
        par_err_q    <= (^word) ^ SI;
`endif
      end else if (dout_valid_q && Dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      // A drop on the same edge as clr_ovr keeps the flag set.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);
  assign bit_cnt    = cnt_q;
`ifdef SIPO_RX_PARITY_EN
  assign par_err    = par_err_q;
`endif

endmodule
